exec_latency_pipe: RTL

EXEC_LATENCY_PIPE -- requirements
Module: exec_latency_pipe

---
 rtl/exec_pipe_pkg.sv | 9 +
 rtl/exec_pipe_stage.sv | 41 ++++
 rtl/exec_latency_pipe.sv | 106 ++++++++++
 3 files changed

// File: rtl/exec_pipe_pkg.sv
// Shared defaults for the fixed-latency execution pipe and its stage registers.
package exec_pipe_pkg;

   localparam int DEPTH_DEFAULT = 6;
   localparam int WIDTH_DEFAULT = 32;
   localparam int TAG_W_DEFAULT = 4;
   localparam int DEPTH_MAX     = 16;

endpackage

// File: rtl/exec_pipe_stage.sv
// One pipe stage: valid bit plus payload/tag register with kill/load/clear/hold control.
module exec_pipe_stage
   import exec_pipe_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int TAG_W = TAG_W_DEFAULT
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             kill,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_data,
   input  logic [TAG_W-1:0] load_tag,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [TAG_W-1:0] tag
);

   // Priority kill > load > clear > hold; a stage refilled while advancing stays valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         tag   <= '0;
      end else begin
         if (kill)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         else if (clear)
            valid <= 1'b0;

         if (load && !kill) begin
            data <= load_data;
            tag  <= load_tag;
         end
      end
   end

endmodule

// File: rtl/exec_latency_pipe.sv
// Fixed-latency execution pipe with bubble collapsing and flush; entries enter at DEPTH-1, leave at 0.
// Optional occupancy output enabled by defining EXEC_LATENCY_PIPE_OCC_EN.
module exec_latency_pipe
   import exec_pipe_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int TAG_W = TAG_W_DEFAULT
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   input  logic             flush
`ifdef EXEC_LATENCY_PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0]            adv;
   logic [DEPTH-1:0][WIDTH-1:0] stage_data;
   logic [DEPTH-1:0][TAG_W-1:0] stage_tag;
   logic                        accept;

   // A stage advances when it is live and the stage below is empty or advancing itself.
   always_comb begin
      adv    = '0;
      adv[0] = v[0] & out_ready & ~flush;
      for (int i = 1; i < DEPTH; i++)
         adv[i] = v[i] & (~v[i-1] | adv[i-1]);
   end

   assign in_ready  = ~v[DEPTH-1] | adv[DEPTH-1];
   assign accept    = in_valid & in_ready;
   assign out_valid = v[0] & ~flush;
   assign out_data  = stage_data[0];
   assign out_tag   = stage_tag[0];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
         logic             load;
         logic [WIDTH-1:0] src_data;
         logic [TAG_W-1:0] src_tag;

         if (gi == DEPTH-1) begin : g_entry
            assign load     = accept;
            assign src_data = in_data;
            assign src_tag  = in_tag;
         end else begin : g_inner
            assign load     = adv[gi+1];
            assign src_data = stage_data[gi+1];
            assign src_tag  = stage_tag[gi+1];
         end

         exec_pipe_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .kill      (flush),
            .load      (load),
            .clear     (adv[gi]),
            .load_data (src_data),
            .load_tag  (src_tag),
            .valid     (v[gi]),
            .data      (stage_data[gi]),
            .tag       (stage_tag[gi])
         );
      end
   endgenerate

`ifdef EXEC_LATENCY_PIPE_OCC_EN
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [OCC_W-1:0] occ_reg;
   logic [OCC_W-1:0] occ_next;

   // Collapsing moves never change the count; only accept, retire and flush do.
   always_comb begin
      occ_next = occ_reg;
      if (flush)
         occ_next = '0;
      else
         occ_next = occ_reg + OCC_W'(accept) - OCC_W'(adv[0]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         occ_reg <= '0;
      else
         occ_reg <= occ_next;
   end

   assign occupancy = occ_reg;
`endif

endmodule
